// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter with bounded lock for a shared 1Kx32 memory

module mem_arbiter #(
    parameter int LOCK_MAX = 8
) (
    input  logic        clk,
    input  logic        reset_i,

    input  logic        p0_req_i,
    output logic        p0_ready_o,
    input  logic [31:0] p0_addr_i,
    input  logic        p0_we_i,
    input  logic [3:0]  p0_wr_mask_i,
    input  logic [31:0] p0_wdata_i,
    input  logic        p0_lock_i,
    output logic        p0_rsp_valid_o,
    output logic [31:0] p0_rdata_o,

    input  logic        p1_req_i,
    output logic        p1_ready_o,
    input  logic [31:0] p1_addr_i,
    input  logic        p1_we_i,
    input  logic [3:0]  p1_wr_mask_i,
    input  logic [31:0] p1_wdata_i,
    input  logic        p1_lock_i,
    output logic        p1_rsp_valid_o,
    output logic [31:0] p1_rdata_o,

    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wr_mask_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,

    output logic        lock_timeout_o
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;
    logic          rsp_pend_q, rsp_pend_d;
    logic          rsp_port_q, rsp_port_d;
    logic [31:0]   addr_q, addr_d;

    logic        gnt0, gnt1;
    logic        hs;
    logic        hs_port;
    logic        hs_lock;
    logic        hs_we;
    logic [31:0] hs_addr;
    logic        release_hs;
    logic        timeout;

    // Grant: round-robin against last in ARB, owner-only while LOCKED, nothing during reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset_i) begin
            if (state_q == ARB) begin
                if (p0_req_i && p1_req_i) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt0 = p0_req_i;
                    gnt1 = p1_req_i;
                end
            end else begin
                gnt0 = !owner_q && p0_req_i;
                gnt1 = owner_q && p1_req_i;
            end
        end
    end

    assign hs      = gnt0 | gnt1;
    assign hs_port = gnt1;
    assign hs_lock = gnt1 ? p1_lock_i : p0_lock_i;
    assign hs_we   = gnt1 ? p1_we_i   : p0_we_i;
    assign hs_addr = gnt1 ? p1_addr_i : p0_addr_i;

    assign p0_ready_o = gnt0;
    assign p1_ready_o = gnt1;

    assign mem_addr_o    = hs ? hs_addr : addr_q;
    assign mem_we_o      = hs & hs_we;
    assign mem_wr_mask_o = gnt1 ? p1_wr_mask_i : p0_wr_mask_i;
    assign mem_data_o    = gnt1 ? p1_wdata_i   : p0_wdata_i;

    assign p0_rsp_valid_o = rsp_pend_q & (rsp_port_q == 1'b0);
    assign p1_rsp_valid_o = rsp_pend_q & (rsp_port_q == 1'b1);
    assign p0_rdata_o     = mem_data_i;
    assign p1_rdata_o     = mem_data_i;

    assign lock_timeout_o = timeout;

    // Next-state: lock entry/release/forced timeout, response tracking, held address
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        lock_cnt_d = lock_cnt_q;
        rsp_pend_d = hs;
        rsp_port_d = rsp_port_q;
        addr_d     = addr_q;
        release_hs = 1'b0;
        timeout    = 1'b0;

        if (hs) begin
            last_d     = hs_port;
            rsp_port_d = hs_port;
            addr_d     = hs_addr;
        end

        case (state_q)
            ARB: begin
                if (hs && hs_lock) begin
                    state_d    = LOCKED;
                    owner_d    = hs_port;
                    lock_cnt_d = '0;
                end
            end
            LOCKED: begin
                lock_cnt_d = lock_cnt_q + CW'(1);
                // Only the owner can handshake here, so any unlocked handshake is the release
                release_hs = hs && !hs_lock;
                if (release_hs) begin
                    state_d = ARB;
                end else if (lock_cnt_q == CNT_LAST) begin
                    state_d = ARB;
                    timeout = 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // State registers; reset drops any in-flight response and any held lock
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ARB;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            lock_cnt_q <= '0;
            rsp_pend_q <= 1'b0;
            rsp_port_q <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_port_q <= rsp_port_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter

module tb_mem_arbiter;

    localparam int LOCK_MAX = 8;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        p0_req_i = 0, p0_we_i = 0, p0_lock_i = 0;
    logic [31:0] p0_addr_i = 0, p0_wdata_i = 0;
    logic [3:0]  p0_wr_mask_i = 0;
    logic        p1_req_i = 0, p1_we_i = 0, p1_lock_i = 0;
    logic [31:0] p1_addr_i = 0, p1_wdata_i = 0;
    logic [3:0]  p1_wr_mask_i = 0;
    logic        p0_ready_o, p1_ready_o, p0_rsp_valid_o, p1_rsp_valid_o;
    logic [31:0] p0_rdata_o, p1_rdata_o;
    logic [31:0] mem_addr_o, mem_data_o;
    logic        mem_we_o;
    logic [3:0]  mem_wr_mask_o;
    logic [31:0] mem_data_i;
    logic        lock_timeout_o;

    int checks = 0;
    int failures = 0;

    mem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .reset_i(reset_i),
        .p0_req_i(p0_req_i), .p0_ready_o(p0_ready_o), .p0_addr_i(p0_addr_i),
        .p0_we_i(p0_we_i), .p0_wr_mask_i(p0_wr_mask_i), .p0_wdata_i(p0_wdata_i),
        .p0_lock_i(p0_lock_i), .p0_rsp_valid_o(p0_rsp_valid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_ready_o(p1_ready_o), .p1_addr_i(p1_addr_i),
        .p1_we_i(p1_we_i), .p1_wr_mask_i(p1_wr_mask_i), .p1_wdata_i(p1_wdata_i),
        .p1_lock_i(p1_lock_i), .p1_rsp_valid_o(p1_rsp_valid_o), .p1_rdata_o(p1_rdata_o),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wr_mask_o(mem_wr_mask_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .lock_timeout_o(lock_timeout_o)
    );

    always #5 clk = ~clk;

    // Memory: synchronous read of the old word, byte-masked write
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        mem_data_i <= mem[mem_addr_o[9:0]];
        if (mem_we_o)
            mem[mem_addr_o[9:0]] = merge(mem[mem_addr_o[9:0]], mem_data_o, mem_wr_mask_o);
    end

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Reference model: lock tracked as elapsed cycles since the locking handshake
    logic [31:0] smem [0:1023];
    bit          m_locked, m_owner, m_last;
    int          m_cycle, m_lock_start;
    bit          m_rsp_pend, m_rsp_port;
    logic [31:0] m_rsp_data, m_addr_hold;
    bit          m_addr_known;
    bit          e_g0, e_g1, e_to, e_hs, e_port, e_lock, e_rel;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic at_neg();
        logic [31:0] a;
        @(negedge clk);
        if (reset_i) begin
            m_locked = 0; m_last = 1; m_rsp_pend = 0; m_addr_known = 0;
        end
        e_g0 = 0; e_g1 = 0;
        if (!reset_i) begin
            if (!m_locked) begin
                if (p0_req_i && p1_req_i) begin
                    if (m_last) e_g0 = 1; else e_g1 = 1;
                end else begin
                    e_g0 = p0_req_i; e_g1 = p1_req_i;
                end
            end else if (m_owner) e_g1 = p1_req_i;
            else e_g0 = p0_req_i;
        end
        e_hs   = e_g0 | e_g1;
        e_port = e_g1;
        e_lock = e_port ? p1_lock_i : p0_lock_i;
        e_rel  = m_locked && e_hs && !e_lock;
        e_to   = m_locked && !e_rel && (m_cycle - m_lock_start == LOCK_MAX);
        chk("p0_ready", 32'(p0_ready_o), 32'(e_g0));
        chk("p1_ready", 32'(p1_ready_o), 32'(e_g1));
        chk("mem_we", 32'(mem_we_o), 32'(e_hs && (e_port ? p1_we_i : p0_we_i)));
        chk("lock_timeout", 32'(lock_timeout_o), 32'(e_to));
        chk("p0_rsp_valid", 32'(p0_rsp_valid_o), 32'(m_rsp_pend && !m_rsp_port));
        chk("p1_rsp_valid", 32'(p1_rsp_valid_o), 32'(m_rsp_pend && m_rsp_port));
        if (m_rsp_pend)
            chk(m_rsp_port ? "p1_rdata" : "p0_rdata", m_rsp_port ? p1_rdata_o : p0_rdata_o, m_rsp_data);
        if (e_hs) begin
            a = e_port ? p1_addr_i : p0_addr_i;
            chk("mem_addr", mem_addr_o, a);
            if (e_port ? p1_we_i : p0_we_i) begin
                chk("mem_mask", 32'(mem_wr_mask_o), 32'(e_port ? p1_wr_mask_i : p0_wr_mask_i));
                chk("mem_data", mem_data_o, e_port ? p1_wdata_i : p0_wdata_i);
            end
        end else if (m_addr_known) begin
            chk("mem_addr_hold", mem_addr_o, m_addr_hold);
        end
    endtask

    task automatic at_pos();
        logic [31:0] a;
        @(posedge clk);
        if (!reset_i) begin
            if (e_hs) begin
                a = e_port ? p1_addr_i : p0_addr_i;
                m_rsp_pend = 1; m_rsp_port = e_port; m_rsp_data = smem[a[9:0]];
                if (e_port ? p1_we_i : p0_we_i)
                    smem[a[9:0]] = merge(smem[a[9:0]], e_port ? p1_wdata_i : p0_wdata_i,
                                         e_port ? p1_wr_mask_i : p0_wr_mask_i);
                m_last = e_port; m_addr_hold = a; m_addr_known = 1;
            end else begin
                m_rsp_pend = 0;
            end
            if (!m_locked && e_hs && e_lock) begin
                m_locked = 1; m_owner = e_port; m_lock_start = m_cycle;
            end else if (m_locked && (e_rel || e_to)) begin
                m_locked = 0;
            end
        end
        m_cycle++;
        #1;
    endtask

    task automatic idle_inputs();
        p0_req_i = 0; p0_we_i = 0; p0_lock_i = 0;
        p1_req_i = 0; p1_we_i = 0; p1_lock_i = 0;
    endtask

    typedef struct {
        bit p0_req; bit p1_req; bit p1_lock;
        bit r0; bit r1; bit to; bit v0; bit v1;
    } vec_t;
    vec_t vt[12];

    int n, tos, to_at;
    bit got;

    initial begin
        vt[0]  = '{1,1,0, 1,0,0, 0,0};
        vt[1]  = '{1,1,0, 0,1,0, 1,0};
        vt[2]  = '{1,1,0, 1,0,0, 0,1};
        vt[3]  = '{1,1,0, 0,1,0, 1,0};
        vt[4]  = '{0,0,0, 0,0,0, 0,1};
        vt[5]  = '{1,0,0, 1,0,0, 0,0};
        vt[6]  = '{1,1,1, 0,1,0, 1,0};
        vt[7]  = '{1,1,1, 0,1,0, 0,1};
        vt[8]  = '{1,1,1, 0,1,0, 0,1};
        vt[9]  = '{1,1,0, 0,1,0, 0,1};
        vt[10] = '{1,1,0, 1,0,0, 0,1};
        vt[11] = '{0,0,0, 0,0,0, 1,0};

        for (int i = 0; i < 1024; i++) begin
            mem[i] = $urandom();
            smem[i] = mem[i];
        end
        mem[4] = 32'hDEADBEEF; smem[4] = 32'hDEADBEEF;
        mem[7] = 32'h0;        smem[7] = 32'h0;
        m_cycle = 0; m_lock_start = 0; m_owner = 0;

        // Reset state, with requests pending to confirm they are ignored
        p0_req_i = 1; p1_req_i = 1; p1_we_i = 1;
        at_neg();
        chk("rst_p0_ready", 32'(p0_ready_o), 0);
        chk("rst_mem_we", 32'(mem_we_o), 0);
        at_pos();
        at_neg(); at_pos();
        idle_inputs();
        reset_i = 0;

        // Contention, then p1 lock x3 and release while p0 waits
        for (int i = 0; i < 12; i++) begin
            p0_req_i = vt[i].p0_req; p0_addr_i = 32'(i);
            p1_req_i = vt[i].p1_req; p1_addr_i = 32'(100 + i); p1_lock_i = vt[i].p1_lock;
            at_neg();
            chk($sformatf("vec%0d_r0", i), 32'(p0_ready_o), 32'(vt[i].r0));
            chk($sformatf("vec%0d_r1", i), 32'(p1_ready_o), 32'(vt[i].r1));
            chk($sformatf("vec%0d_to", i), 32'(lock_timeout_o), 32'(vt[i].to));
            chk($sformatf("vec%0d_v0", i), 32'(p0_rsp_valid_o), 32'(vt[i].v0));
            chk($sformatf("vec%0d_v1", i), 32'(p1_rsp_valid_o), 32'(vt[i].v1));
            at_pos();
        end
        idle_inputs();

        // Single p0 read of word 4
        p0_req_i = 1; p0_addr_i = 32'h4;
        at_neg(); chk("rd_ready", 32'(p0_ready_o), 1); at_pos();
        idle_inputs();
        at_neg();
        chk("rd_v0", 32'(p0_rsp_valid_o), 1);
        chk("rd_v1", 32'(p1_rsp_valid_o), 0);
        chk("rd_data", p0_rdata_o, 32'hDEADBEEF);
        at_pos();

        // Lock timeout: p1 locks alone, then idles while p0 waits
        p1_req_i = 1; p1_lock_i = 1; p1_addr_i = 32'h20;
        at_neg(); chk("to_lock_gnt", 32'(p1_ready_o), 1); at_pos();
        idle_inputs();
        p0_req_i = 1; p0_addr_i = 32'h21;
        n = 0; tos = 0; to_at = -1; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            at_neg();
            if (p0_ready_o) got = 1;
            else begin
                n++;
                if (lock_timeout_o) begin tos++; to_at = n; end
            end
            at_pos();
        end
        chk("to_p0_granted", 32'(got), 1);
        chk("to_locked_cycles", 32'(n), 32'(LOCK_MAX));
        chk("to_pulses", 32'(tos), 1);
        chk("to_pulse_cycle", 32'(to_at), 32'(LOCK_MAX));
        idle_inputs();
        at_neg(); at_pos();

        // Masked write to word 7, then read it back
        p1_req_i = 1; p1_we_i = 1; p1_addr_i = 32'h7;
        p1_wr_mask_i = 4'b0101; p1_wdata_i = 32'h11223344;
        at_neg(); chk("wr_mask_out", 32'(mem_wr_mask_o), 32'h5); at_pos();
        p1_we_i = 0;
        at_neg();
        chk("wr_rsp_v1", 32'(p1_rsp_valid_o), 1);
        chk("wr_rsp_old", p1_rdata_o, 32'h0);
        at_pos();
        idle_inputs();
        at_neg(); chk("rb_data", p1_rdata_o, 32'h00220044); at_pos();

        // Reset one cycle after a p0 read handshake
        p0_req_i = 1; p0_addr_i = 32'h4;
        at_neg(); at_pos();
        reset_i = 1; p1_req_i = 1; p1_we_i = 1;
        at_neg();
        chk("mid_rst_v0", 32'(p0_rsp_valid_o), 0);
        chk("mid_rst_r0", 32'(p0_ready_o), 0);
        chk("mid_rst_r1", 32'(p1_ready_o), 0);
        chk("mid_rst_we", 32'(mem_we_o), 0);
        at_pos();
        reset_i = 0; p1_we_i = 0;
        at_neg(); chk("post_rst_p0_first", 32'(p0_ready_o), 1); at_pos();
        idle_inputs();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset_i      = ($urandom_range(0, 149) == 0);
            p0_req_i     = ($urandom_range(0, 3) != 0);
            p1_req_i     = ($urandom_range(0, 3) != 0);
            p0_lock_i    = ($urandom_range(0, 4) == 0);
            p1_lock_i    = ($urandom_range(0, 3) == 0);
            p0_we_i      = ($urandom_range(0, 2) == 0);
            p1_we_i      = ($urandom_range(0, 2) == 0);
            p0_addr_i    = $urandom() & 32'h0000_F00F;
            p1_addr_i    = $urandom() & 32'h0000_F00F;
            p0_wr_mask_i = 4'($urandom());
            p1_wr_mask_i = 4'($urandom());
            p0_wdata_i   = $urandom();
            p1_wdata_i   = $urandom();
            at_neg(); at_pos();
        end
        reset_i = 0;
        idle_inputs();
        at_neg(); at_pos();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port, byte-maskable 1K×32 synchronous-read memory between the instruction-fetch requester (port 0) and the load/store requester (port 1). Grants one request per cycle using round-robin. Supports a bounded lock so port 1 can do atomic read-modify-write sequences. Routes each read response back to the issuing port one cycle after the memory access.

## Interface
- `LOCK_MAX`, default 8: maximum consecutive cycles spent in LOCKED before a forced release (≥1).
- `clk` in 1: single clock, rising edge.
- `reset_i` in 1: asynchronous, active-high reset.
- `pN_req_i` in 1 (N=0,1): request valid.
- `pN_ready_o` out 1: request accepted this cycle. Handshake = `pN_req_i & pN_ready_o`.
- `pN_addr_i` in 32: word address; only [9:0] is meaningful downstream.
- `pN_we_i` in 1: write request.
- `pN_wr_mask_i` in 4: byte-lane enables for writes.
- `pN_wdata_i` in 32: write data.
- `pN_lock_i` in 1: keep the grant after this request.
- `pN_rsp_valid_o` out 1: one-cycle pulse, response for this port's previous handshake.
- `pN_rdata_o` in/out 32 (out): read data, valid while `pN_rsp_valid_o` is high.
- `mem_addr_o` out 32: memory address.
- `mem_we_o` out 1: memory write enable.
- `mem_wr_mask_o` out 4: memory byte mask.
- `mem_data_o` out 32: memory write data.
- `mem_data_i` in 32: memory read data, registered by the memory with 1-cycle latency.
- `lock_timeout_o` out 1: one-cycle pulse when a lock is force-released.

## Operation
- **State:**
  - FSM has states ARB and LOCKED.
  - `owner` (1 bit) records the locked port.
  - `last` (1 bit) records the last granted port.
  - `lock_cnt` is clog2(LOCK_MAX+1) bits.
  - `rsp_pend` (1 bit) and `rsp_port` (1 bit) track the in-flight response.
- **Grant rules in ARB:**
  - One requester: that requester is granted.
  - Both requesting: grant the port ≠ `last`.
  - No requester: no grant.
- **Grant rules in LOCKED:** only `owner` may be granted; the other port's ready stays 0.
- **Grant signalling:** grant is combinational from the requests and state. `pN_ready_o` = grant to port N. At most one ready is high per cycle.
- **Memory outputs:**
  - On a granted cycle, `mem_*` are driven from the granted port's inputs.
  - `mem_we_o` = granted `we_i`, and is 0 when there is no grant.
  - On idle cycles `mem_addr_o` holds the last address; the mask and data values are don't-care.
- **On each handshake:**
  - `last` ← granted port.
  - `rsp_pend` ← 1 and `rsp_port` ← granted port.
  - With no handshake, `rsp_pend` ← 0.
- **Responses:**
  - `pN_rsp_valid_o` = `rsp_pend & (rsp_port==N)`.
  - `pN_rdata_o` = `mem_data_i`, passed through to both ports.
  - Writes also return a response pulse, with rdata = the pre-write word (the memory reads old data).
  - Requesters cannot back-pressure responses.
- **FSM transitions:**
  - ARB → LOCKED on a handshake with `lock_i`=1. Set `owner` to that port and `lock_cnt` to 0.
  - In LOCKED, `lock_cnt` increments every cycle.
  - LOCKED → ARB when `owner` handshakes with `lock_i`=0. That request is still serviced.
  - LOCKED → ARB on forced release when `lock_cnt` == LOCK_MAX−1 and there is no release handshake. `lock_timeout_o` pulses that cycle. A handshake with `lock_i`=1 in that same cycle is serviced, but the lock is not renewed.
- **Simultaneous release and timeout:** treated as a normal release; no timeout pulse.
- **Re-lock after forced release:** the next ARB arbitration still uses `last`. A port that was force-released is therefore not granted first if the other port is waiting.

## Timing
- **Reset values (asynchronous assert):**
  - state = ARB, `last` = 1 (so port 0 wins the first contention), `owner` = 0, `lock_cnt` = 0, `rsp_pend` = 0.
  - `lock_timeout_o` = 0.
  - `pN_rsp_valid_o` = 0.
  - `pN_ready_o` = 0 while `reset_i` is high.
  - `mem_we_o` = 0 while `reset_i` is high.
- **Request to memory:** 0 cycles (combinational).
- **Request to response:** handshake in cycle T gives rsp_valid/rdata in cycle T+1.
- **Throughput:** one access per cycle with back-to-back grants; alternate ports are interleaved under contention.
- **Reset mid-lock:** returns the FSM to ARB immediately. An in-flight response is dropped (`rsp_pend` cleared).
- **Lock hold limit:** a lock holds the memory at most LOCK_MAX cycles after the locking handshake.

## Test plan
- **Single port read:** p0 reads 0x004 (word holds 0xDEADBEEF) → `p0_ready_o`=1 same cycle; next cycle `p0_rsp_valid_o`=1 and `p0_rdata_o`=0xDEADBEEF; `p1_rsp_valid_o`=0.
- **Contention after reset:** both ports request continuously for 4 cycles → grants go p0, p1, p0, p1; each response pulse arrives one cycle later on the matching port.
- **Masked write then read:** p1 writes 0x11223344 with mask 0b0101 to word 7 (previously 0), then reads word 7 → read returns 0x00220044; the write response returns 0.
- **Lock with release:** p1 issues 3 lock=1 requests, then one lock=0, while p0 requests continuously → p0 gets no grants for those 4 handshakes; p0 is granted the cycle after the release; `lock_timeout_o`=0.
- **Lock timeout:** LOCK_MAX=8, p1 locks then idles → exactly 8 cycles in LOCKED, `lock_timeout_o` pulses once, p0 is granted the next cycle.
- **Reset mid-operation:** assert `reset_i` one cycle after a p0 read handshake → no `p0_rsp_valid_o` pulse; all outputs take their reset values immediately.
